fp_add_operand_issue: RTL

- Issue stage directly upstream of the combinational FP32 adder.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Applies add/subtract sign handling and swaps each pair so the first operand's exponent is never smaller than the second's.
- Presents one registered, pre-ordered pair per handshake to the adder input, plus per-pair flags.

---
 rtl/fp_add_operand_issue.sv | 107 ++++++++++
 1 files changed

// File: rtl/fp_add_operand_issue.sv
// rtl/fp_add_operand_issue.sv - FP32 adder issue stage: operand FIFO, sign handling,
// exponent-ordered swap and a registered output pair with per-pair flags.
module fp_add_operand_issue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_swapped,
    output logic             out_special,
    output logic             out_b_zero,
    output logic [CNT_W-1:0] issue_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          push;
    logic          load;
    logic [31:0]   head_a;
    logic [31:0]   head_b;
    logic [31:0]   nxt_a;
    logic [31:0]   nxt_b;
    logic          nxt_swapped;
    logic          nxt_special;

    // Full blocks the push even if the head pops this cycle.
    assign in_ready = !rst && (occ < FULL);
    assign push     = in_valid && in_ready;
    assign load     = (occ != '0) && (!out_valid || out_ready);

    assign head_a = mem[rd_ptr][63:32];
    assign head_b = mem[rd_ptr][31:0];

    always_comb begin
        nxt_a       = head_a;
        nxt_b       = head_b;
        nxt_swapped = 1'b0;
        if (head_a[30:23] < head_b[30:23]) begin
            nxt_a       = head_b;
            nxt_b       = head_a;
            nxt_swapped = 1'b1;
        end
        nxt_special = (head_a[30:23] == 8'hFF) || (head_b[30:23] == 8'hFF);
    end

    // Subtraction is folded into B's sign at push time so in_sub is never stored.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b[31] ^ in_sub, in_b[30:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_swapped <= 1'b0;
            out_special <= 1'b0;
            out_b_zero  <= 1'b0;
            issue_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, load})
                2'b10:   occ <= occ + (AW + 1)'(1);
                2'b01:   occ <= occ - (AW + 1)'(1);
                default: occ <= occ;
            endcase

            if (load) begin
                out_valid   <= 1'b1;
                out_a       <= nxt_a;
                out_b       <= nxt_b;
                out_swapped <= nxt_swapped;
                out_special <= nxt_special;
                out_b_zero  <= (nxt_b[30:0] == 31'd0);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready) begin
                issue_count <= issue_count + CNT_W'(1);
            end
        end
    end
endmodule
